ps2_rx_scan: RTL

PS2_RX_SCAN -- requirements
Module: ps2_rx_scan

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_clk_filter.sv | 43 ++++
 rtl/ps2_rx_scan.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 receiver state encoding, scan-code constants and parity helper
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    // PS/2 uses odd parity across the eight data bits plus the parity bit
    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// rtl/ps2_clk_filter.sv - 2-flop synchronizer plus FILTER_LEN-sample glitch filter with fall pulse
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic fall
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          differ;
    logic          flip;

    assign differ = (sync[1] != level);
    // cnt holds the number of earlier differing samples, so this is the FILTER_LEN-th one
    assign flip   = differ && (cnt == CW'(FILTER_LEN - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync  <= 2'b11;
            cnt   <= '0;
            level <= 1'b1;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            fall <= flip & level;
            if (flip) begin
                level <= ~level;
                cnt   <= '0;
            end else if (differ) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_rx_scan.sv
// rtl/ps2_rx_scan.sv - PS/2 scan-code receiver; optional break-code filter via PS2_BREAK_FILTER_EN
module ps2_rx_scan
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic [7:0] ps2_data,
    output logic       ps2_new_data,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic          c_level;
    logic          c_fall;
    logic          d_level;
    logic          unused_data_fall;

    ps2_state_t    state;
    ps2_state_t    state_next;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          accept_evt;
    logic          perr_evt;
    logic          ferr_evt;
    logic          emit;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (clk),
        .reset (reset),
        .raw   (ps2c),
        .level (c_level),
        .fall  (c_fall)
    );

    // Same filter on data keeps it time-aligned with the filtered clock
    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
        .clk   (clk),
        .reset (reset),
        .raw   (ps2d),
        .level (d_level),
        .fall  (unused_data_fall)
    );

    assign tmo_hit = (state != ST_IDLE) && !c_fall && (tmo_cnt == TW'(TIMEOUT_CYC));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (tmo_hit) begin
            state_next = ST_IDLE;
        end else if (c_fall) begin
            case (state)
                ST_IDLE:   if (!d_level) state_next = ST_DATA;
                ST_DATA:   if (bit_cnt == 3'd7) state_next = ST_PARITY;
                ST_PARITY: state_next = ST_STOP;
                ST_STOP:   state_next = ST_IDLE;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        accept_evt = 1'b0;
        perr_evt   = 1'b0;
        ferr_evt   = 1'b0;
        if (tmo_hit) begin
            ferr_evt = 1'b1;
        end else if (c_fall) begin
            case (state)
                ST_IDLE: ferr_evt = d_level;
                ST_STOP: begin
                    if (!d_level) begin
                        ferr_evt = 1'b1;
                    end else if (!parity_ok(shreg, par_bit)) begin
                        perr_evt = 1'b1;
                    end else begin
                        accept_evt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt <= 3'd0;
            shreg   <= 8'h00;
            par_bit <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            if (tmo_hit) begin
                bit_cnt <= 3'd0;
            end else if (c_fall) begin
                case (state)
                    ST_IDLE:   bit_cnt <= 3'd0;
                    ST_DATA: begin
                        shreg   <= {d_level, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    ST_PARITY: par_bit <= d_level;
                    default:   ;
                endcase
            end

            if (state_next == ST_IDLE || c_fall) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != '1) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

`ifdef PS2_BREAK_FILTER_EN
    logic break_pending;

    // F0 arms the flag and is swallowed; the byte that follows is swallowed and disarms it
    assign emit = accept_evt && !break_pending && (shreg != PS2_BREAK);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            break_pending <= 1'b0;
        end else if (accept_evt) begin
            break_pending <= !break_pending && (shreg == PS2_BREAK);
        end
    end
`else
    assign emit = accept_evt;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps2_data     <= 8'h00;
            ps2_new_data <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            ps2_new_data <= emit;
            parity_err   <= perr_evt;
            frame_err    <= ferr_evt;
            if (emit) begin
                ps2_data <= shreg;
            end
        end
    end

endmodule
